ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
//  Execute-to-memory pipeline boundary; sits directly downstream of the ALU.
//  Registers the ALU result, store data and destination register behind a valid/ready handshake.
//  A 2-entry skid buffer keeps upstream ready registered (no comb ready path).
//  Resolves conditional and unconditional branches from the ALU flags; issues a one-cycle PC redirect.
// PARAMETERS
//  DATA_W    REG_WIDTH  datapath width; const_pkg value, 32
//  RD_W      5          destination register index width
// PORTS
//  i_clk            in   1       single clock, rising edge
//  i_rst_n          in   1       reset: asynchronous, active-low
//  i_valid          in   1       upstream (ALU side) entry valid
//  o_ready          out  1       stage can accept; registered
//  i_result         in   DATA_W  ALU o_result
//  i_zero           in   1       ALU o_zero
//  i_less_than      in   1       ALU o_less_than (signed/unsigned already selected)
//  i_br_type        in   3       branch_type_t
//  i_pc             in   DATA_W  PC of the instruction
//  i_imm            in   DATA_W  immediate (branch/JAL offset)
//  i_rs2            in   DATA_W  store data
//  i_rd             in   RD_W    destination register; 0 = no write
//  i_flush          in   1       squash all held and incoming entries
//  o_valid          out  1       entry available to MEM
//  i_ready          in   1       MEM accepts
//  o_result         out  DATA_W  ALU result, or link value for JAL/JALR
//  o_rs2            out  DATA_W  store data
//  o_rd             out  RD_W    destination register
//  o_redirect       out  1       one-cycle pulse: taken branch/jump
//  o_redirect_pc    out  DATA_W  redirect target; valid only with o_redirect
// BEHAVIOUR
//  Reset: o_valid=0, o_ready=1, o_redirect=0, all data outputs 0, FSM=EMPTY.
//  Accept when i_valid&&o_ready; emit when o_valid&&i_ready. Input latency 1 cycle.
//  FSM: EMPTY (no entry), ONE (main reg), FULL (main + skid).
//   EMPTY: accept -> ONE.
//   ONE:   accept&&!emit -> FULL; emit&&!accept -> EMPTY; both or neither -> ONE.
//   FULL:  o_ready=0; emit -> ONE, skid moves into main.
//  o_ready = (state!=FULL), registered; never depends on i_ready in the same cycle.
//  Order is strict FIFO; data outputs do not change while o_valid&&!i_ready.
//  Branch resolution runs on accept only:
//   BR_NONE none; BR_EQ if i_zero; BR_NE if !i_zero; BR_LT if i_less_than;
//   BR_GE if !i_less_than; BR_JAL and BR_JALR always taken.
//  Target: i_pc+i_imm for conditional branches and JAL; {i_result[DATA_W-1:1],1'b0} for JALR.
//  JAL/JALR: the stored result is i_pc+4, with modulo 2^DATA_W wrap.
//  Redirect is registered: o_redirect high in the cycle after accept, exactly one cycle.
//  Redirect does not drop the entry in the stage; upstream squashes younger work.
//  i_flush: next cycle FSM=EMPTY, o_valid=0, o_ready=1, o_redirect=0.
//  An accept in the flush cycle is dropped, and so is any pending redirect.
//  Flush has priority over accept, emit and redirect.
//  Async reset mid-operation clears all state immediately, with no partial emit.
// CONFIGURATION
//  EX_BR_STATS_EN defined: extra ports o_br_count and o_br_taken_count, 32 bits each, out.
//   Counters clear on reset only, not on flush.
//   o_br_count counts accepted non-BR_NONE entries; o_br_taken_count counts taken ones.
//   Both wrap at 2^32.
//  EX_BR_STATS_EN undefined: those ports and counters do not exist; behaviour otherwise identical.
// STRUCTURE
//  enums_pkg gets: branch_type_t {BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_JAL, BR_JALR}
//   and ex_state_t {EX_EMPTY, EX_ONE, EX_FULL}.
//  cable_pkg gets: ex_mem_entry_t struct {result, rs2, rd}.
//  Branch-resolve logic stays inside this module.
//  One sub-module: skid_buffer, a generic 2-entry valid/ready register on a packed payload.
// TESTING
//  1 Reset: hold i_rst_n=0 -> o_valid=0, o_ready=1, o_redirect=0; release -> same until i_valid.
//  2 Streaming: i_ready=1, 8 back-to-back entries (result 1..8) -> out in order, 1-cycle latency,
//    o_ready stays 1.
//  3 Backpressure: i_ready=0, present 3 entries -> 2 accepted, o_ready=0 after 2nd;
//    i_ready=1 -> results out in order, no loss, no duplicates.
//  4 Branches: BR_EQ, i_zero=1, pc=0x100, imm=0x20 -> o_redirect=1 for one cycle,
//    o_redirect_pc=0x120.
//    BR_NE, i_zero=1 -> no redirect.
//    JALR, i_result=0x203, pc=0x40 -> target 0x202, o_result=0x44.
//  5 Flush: stage FULL, taken branch accepted in same cycle as i_flush -> next cycle o_valid=0,
//    o_ready=1, no redirect.
//  6 EX_BR_STATS_EN: 4 branches, 3 taken, then flush -> counts 4/3, unchanged by the flush.

Source files
------------

// File: rtl/ex_mem_stage_pkg.sv
// Shared types for the EX->MEM boundary: branch encodings, skid FSM states, entry layout.
package ex_mem_stage_pkg;

  localparam int REG_WIDTH = 32;
  localparam int RD_WIDTH  = 5;

  typedef enum logic [2:0] {
    BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_JAL, BR_JALR
  } branch_type_t;

  typedef logic [1:0] ex_state_t;
  localparam ex_state_t EX_EMPTY = 2'd0;
  localparam ex_state_t EX_ONE   = 2'd1;
  localparam ex_state_t EX_FULL  = 2'd2;

  typedef struct packed {
    logic [REG_WIDTH-1:0] result;
    logic [REG_WIDTH-1:0] rs2;
    logic [RD_WIDTH-1:0]  rd;
  } ex_mem_entry_t;

  function automatic logic br_taken(input branch_type_t bt, input logic zero, input logic lt);
    logic t;
    t = 1'b0;
    case (bt)
      BR_EQ:           t = zero;
      BR_NE:           t = !zero;
      BR_LT:           t = lt;
      BR_GE:           t = !lt;
      BR_JAL, BR_JALR: t = 1'b1;
      default:         t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/ex_mem_stage_skid_buffer.sv
// Generic 2-entry valid/ready register; upstream ready is a decode of state flops only.
module skid_buffer
  import ex_mem_stage_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  ex_state_t    state;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         accept;
  logic         emit;

  assign o_ready = (state != EX_FULL);
  assign o_valid = (state != EX_EMPTY);
  assign o_data  = main_q;
  assign accept  = i_valid && o_ready;
  assign emit    = o_valid && i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= EX_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (i_flush) begin
      state <= EX_EMPTY;
    end else begin
      case (state)
        EX_EMPTY: if (accept) begin
          main_q <= i_data;
          state  <= EX_ONE;
        end
        EX_ONE: begin
          if (accept && emit) begin
            main_q <= i_data;
          end else if (accept) begin
            skid_q <= i_data;
            state  <= EX_FULL;
          end else if (emit) begin
            state <= EX_EMPTY;
          end
        end
        // Held entry stays in skid until main drains; ready is low so nothing new arrives.
        EX_FULL: if (emit) begin
          main_q <= skid_q;
          state  <= EX_ONE;
        end
        default: state <= EX_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with branch resolution and a registered one-cycle PC redirect.
// Optional build macro EX_BR_STATS_EN adds branch / taken-branch counters.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int DATA_W = REG_WIDTH,
  parameter int RD_W   = RD_WIDTH
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_result,
  input  logic              i_zero,
  input  logic              i_less_than,
  input  branch_type_t      i_br_type,
  input  logic [DATA_W-1:0] i_pc,
  input  logic [DATA_W-1:0] i_imm,
  input  logic [DATA_W-1:0] i_rs2,
  input  logic [RD_W-1:0]   i_rd,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_result,
  output logic [DATA_W-1:0] o_rs2,
  output logic [RD_W-1:0]   o_rd,
  output logic              o_redirect,
`ifdef EX_BR_STATS_EN
  output logic [31:0]       o_br_count,
  output logic [31:0]       o_br_taken_count,
`endif
  output logic [DATA_W-1:0] o_redirect_pc
);

  localparam int PW = 2*DATA_W + RD_W;

  logic              accept;
  logic              taken;
  logic              is_link;
  logic [DATA_W-1:0] target;
  logic [DATA_W-1:0] res_in;
  logic [PW-1:0]     pld_in;
  logic [PW-1:0]     pld_out;

  assign accept  = i_valid && o_ready;
  assign taken   = br_taken(i_br_type, i_zero, i_less_than);
  assign is_link = (i_br_type == BR_JAL) || (i_br_type == BR_JALR);
  assign target  = (i_br_type == BR_JALR) ? {i_result[DATA_W-1:1], 1'b0} : i_pc + i_imm;
  assign res_in  = is_link ? i_pc + DATA_W'(4) : i_result;
  assign pld_in  = {res_in, i_rs2, i_rd};

  skid_buffer #(.W(PW)) u_skid (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (pld_in),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (pld_out)
  );

  assign {o_result, o_rs2, o_rd} = pld_out;

  // Redirect only reflects the accept of the previous cycle; flush kills it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_redirect    <= 1'b0;
      o_redirect_pc <= '0;
    end else if (i_flush) begin
      o_redirect <= 1'b0;
    end else begin
      o_redirect <= accept && taken;
      if (accept && taken) o_redirect_pc <= target;
    end
  end

`ifdef EX_BR_STATS_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_br_count       <= '0;
      o_br_taken_count <= '0;
    end else if (accept && !i_flush && i_br_type != BR_NONE) begin
      o_br_count <= o_br_count + 32'd1;
      if (taken) o_br_taken_count <= o_br_taken_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed + random bench for ex_mem_stage against a queue-based reference model.
module tb_ex_mem_stage;
  import ex_mem_stage_pkg::*;

  logic         i_clk, i_rst_n, i_valid, o_ready, i_zero, i_less_than, i_flush;
  logic         o_valid, i_ready, o_redirect;
  branch_type_t i_br_type;
  logic [31:0]  i_result, i_pc, i_imm, i_rs2, o_result, o_rs2, o_redirect_pc;
  logic [4:0]   i_rd, o_rd;
`ifdef EX_BR_STATS_EN
  logic [31:0]  o_br_count, o_br_taken_count;
`endif

  ex_mem_stage dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_result(i_result), .i_zero(i_zero), .i_less_than(i_less_than),
    .i_br_type(i_br_type), .i_pc(i_pc), .i_imm(i_imm), .i_rs2(i_rs2), .i_rd(i_rd),
    .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
    .o_rs2(o_rs2), .o_rd(o_rd), .o_redirect(o_redirect),
`ifdef EX_BR_STATS_EN
    .o_br_count(o_br_count), .o_br_taken_count(o_br_taken_count),
`endif
    .o_redirect_pc(o_redirect_pc)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] res;
    logic [31:0] rs2;
    logic [4:0]  rd;
  } exp_t;

  exp_t        q[$];
  int          passed = 0;
  int          fails  = 0;
  int          total  = 0;
  logic        exp_redir = 1'b0;
  logic [31:0] exp_pc = '0;
  int unsigned br_cnt = 0;
  int unsigned tk_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_taken(input branch_type_t bt, input logic z, input logic lt);
    return (bt == BR_EQ && z) || (bt == BR_NE && !z) || (bt == BR_LT && lt) ||
           (bt == BR_GE && !lt) || bt == BR_JAL || bt == BR_JALR;
  endfunction

  task automatic drive(input logic v, input logic [31:0] res, input branch_type_t bt,
                       input logic z, input logic lt, input logic [31:0] pc, input logic [31:0] imm);
    i_valid = v; i_result = res; i_br_type = bt; i_zero = z; i_less_than = lt;
    i_pc = pc; i_imm = imm; i_rs2 = res ^ 32'hA5A5_0000; i_rd = res[4:0];
  endtask

  // Compare at the negedge, then advance the model by the upcoming posedge.
  task automatic cycle();
    logic acc, emt, tk;
    exp_t e;
    chk("o_valid", {31'd0, o_valid}, {31'd0, q.size() > 0});
    chk("o_ready", {31'd0, o_ready}, {31'd0, q.size() < 2});
    if (q.size() > 0) begin
      chk("o_result", o_result, q[0].res);
      chk("o_rs2", o_rs2, q[0].rs2);
      chk("o_rd", {27'd0, o_rd}, {27'd0, q[0].rd});
    end
    chk("o_redirect", {31'd0, o_redirect}, {31'd0, exp_redir});
    if (exp_redir) chk("o_redirect_pc", o_redirect_pc, exp_pc);
`ifdef EX_BR_STATS_EN
    chk("o_br_count", o_br_count, br_cnt);
    chk("o_br_taken_count", o_br_taken_count, tk_cnt);
`endif
    acc = i_valid && (q.size() < 2);
    emt = (q.size() > 0) && i_ready;
    tk  = m_taken(i_br_type, i_zero, i_less_than);
    if (i_flush) begin
      q.delete();
      exp_redir = 1'b0;
    end else begin
      if (emt) void'(q.pop_front());
      if (acc) begin
        e.res = (i_br_type == BR_JAL || i_br_type == BR_JALR) ? i_pc + 32'd4 : i_result;
        e.rs2 = i_rs2;
        e.rd  = i_rd;
        q.push_back(e);
        exp_redir = tk;
        if (tk) exp_pc = (i_br_type == BR_JALR) ? {i_result[31:1], 1'b0} : i_pc + i_imm;
        if (i_br_type != BR_NONE) begin
          br_cnt++;
          if (tk) tk_cnt++;
        end
      end else begin
        exp_redir = 1'b0;
      end
    end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  initial begin
    i_rst_n = 1'b0; i_ready = 1'b0; i_flush = 1'b0;
    drive(1'b0, 32'd0, BR_NONE, 1'b0, 1'b0, 32'd0, 32'd0);

    // Reset
    @(negedge i_clk);
    chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_o_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_o_redirect", {31'd0, o_redirect}, 32'd0);
    chk("rst_o_result", o_result, 32'd0);
    chk("rst_o_redirect_pc", o_redirect_pc, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (3) cycle();

    // Streaming
    i_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, k, BR_NONE, 1'b0, 1'b0, 32'h1000, 32'h0);
      cycle();
    end
    i_valid = 1'b0;
    repeat (2) cycle();

    // Backpressure
    i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h10 + k, BR_NONE, 1'b0, 1'b0, 32'h0, 32'h0);
      cycle();
    end
    chk("bp_o_ready_low", {31'd0, o_ready}, 32'd0);
    chk("bp_head", o_result, 32'h10);
    i_valid = 1'b0; i_ready = 1'b1;
    repeat (3) cycle();

    // Branches
    drive(1'b1, 32'h0, BR_EQ, 1'b1, 1'b0, 32'h100, 32'h20);
    cycle();
    i_valid = 1'b0;
    chk("beq_redirect", {31'd0, o_redirect}, 32'd1);
    chk("beq_target", o_redirect_pc, 32'h120);
    cycle();
    chk("beq_one_cycle", {31'd0, o_redirect}, 32'd0);
    drive(1'b1, 32'h0, BR_NE, 1'b1, 1'b0, 32'h100, 32'h20);
    cycle();
    i_valid = 1'b0;
    chk("bne_no_redirect", {31'd0, o_redirect}, 32'd0);
    drive(1'b1, 32'h203, BR_JALR, 1'b0, 1'b0, 32'h40, 32'h0);
    cycle();
    i_valid = 1'b0;
    chk("jalr_target", o_redirect_pc, 32'h202);
    chk("jalr_link", o_result, 32'h44);
    drive(1'b1, 32'h7, BR_JAL, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h8);
    cycle();
    i_valid = 1'b0;
    chk("jal_link_wrap", o_result, 32'h2);
    chk("jal_target_wrap", o_redirect_pc, 32'h6);
    cycle();

    // Flush from FULL, and flush racing a taken-branch accept
    i_ready = 1'b0;
    drive(1'b1, 32'h21, BR_NONE, 1'b0, 1'b0, 32'h0, 32'h0); cycle();
    drive(1'b1, 32'h22, BR_NONE, 1'b0, 1'b0, 32'h0, 32'h0); cycle();
    drive(1'b1, 32'h23, BR_JAL, 1'b0, 1'b0, 32'h200, 32'h40);
    i_flush = 1'b1;
    cycle();
    i_flush = 1'b0; i_valid = 1'b0;
    chk("flush_full_valid", {31'd0, o_valid}, 32'd0);
    chk("flush_full_ready", {31'd0, o_ready}, 32'd1);
    chk("flush_full_redirect", {31'd0, o_redirect}, 32'd0);
    drive(1'b1, 32'h31, BR_NONE, 1'b0, 1'b0, 32'h0, 32'h0); cycle();
    drive(1'b1, 32'h32, BR_EQ, 1'b1, 1'b0, 32'h300, 32'h10);
    i_flush = 1'b1;
    cycle();
    i_flush = 1'b0; i_valid = 1'b0;
    chk("flush_acc_valid", {31'd0, o_valid}, 32'd0);
    chk("flush_acc_redirect", {31'd0, o_redirect}, 32'd0);
    cycle();

    // Async reset mid-operation
    drive(1'b1, 32'h41, BR_JAL, 1'b0, 1'b0, 32'h500, 32'h4); cycle();
    drive(1'b1, 32'h42, BR_NONE, 1'b0, 1'b0, 32'h0, 32'h0);
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, o_valid}, 32'd0);
    chk("arst_ready", {31'd0, o_ready}, 32'd1);
    chk("arst_redirect", {31'd0, o_redirect}, 32'd0);
    q.delete(); exp_redir = 1'b0; br_cnt = 0; tk_cnt = 0;
    i_valid = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    cycle();

    // Branch statistics: 4 branches, 3 taken, then flush
    i_ready = 1'b1;
    drive(1'b1, 32'h0, BR_EQ, 1'b1, 1'b0, 32'h600, 32'h8); cycle();
    drive(1'b1, 32'h0, BR_NE, 1'b1, 1'b0, 32'h604, 32'h8); cycle();
    drive(1'b1, 32'h0, BR_LT, 1'b0, 1'b1, 32'h608, 32'h8); cycle();
    drive(1'b1, 32'h0, BR_JAL, 1'b0, 1'b0, 32'h60C, 32'h8); cycle();
    i_valid = 1'b0; i_flush = 1'b1;
    cycle();
    i_flush = 1'b0;
    cycle();
`ifdef EX_BR_STATS_EN
    chk("stats_count", o_br_count, 32'd4);
    chk("stats_taken", o_br_taken_count, 32'd3);
`endif

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom, branch_type_t'($urandom_range(0, 6)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
      i_ready = ($urandom_range(0, 3) != 0);
      i_flush = ($urandom_range(0, 19) == 0);
      cycle();
    end
    i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
    repeat (3) cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
